// File: rtl/upstream_req_n_data_mc.sv
// Multi-channel upstream DMA request/data formatter: arbitrates channel requests and
// splits each transfer into boundary-safe fragments. UPSTREAM_RR_ARB_EN selects round-robin.
module upstream_req_n_data_mc #(
  parameter int NCH      = 4,
  parameter int TAG_W    = 4,
  parameter int MAX_FRAG = 512
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       channel_req,
  input  logic [NCH*32-1:0]    channel_saddr,
  input  logic [NCH*32-1:0]    channel_daddr,
  input  logic [NCH*16-1:0]    channel_length,
  input  logic [NCH*TAG_W-1:0] channel_tag,
  output logic [NCH-1:0]       channel_busy,
  output logic [NCH-1:0]       channel_done,
  output logic [31:0]          src_addr,
  output logic [31:0]          dst_addr,
  output logic [15:0]          byte_length,
  output logic                 busif_start,
  input  logic [63:0]          aligner_data,
  input  logic                 aligner_data_en,
  input  logic                 tohost_almost_full,
  output logic [63:0]          tohost_data,
  output logic [7:0]           tohost_ctrl,
  output logic                 tohost_valid
);
  // state | meaning
  // IDLE  | arbitrate among non-busy requesters
  // FRAG  | size next fragment, load aligner address/length
  // INIT  | wait for FIFO room, start aligner, write descriptor qword 0
  // DESC  | write descriptor qword 1 (destination address)
  // DATA  | forward payload qwords until the fragment is drained
  // DONE  | pulse done, release channel
  typedef enum logic [2:0] {IDLE, FRAG, INIT, DESC, DATA, DONE} state_t;

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int FW = $clog2(MAX_FRAG);

  state_t            state;
  logic [CW-1:0]     ch;
  logic [31:0]       src_r, dst_r;
  logic [15:0]       rem_r, cnt;
  logic [TAG_W-1:0]  tag_r;
  logic              first;

  logic [31:0]       saddr_a [NCH];
  logic [31:0]       daddr_a [NCH];
  logic [15:0]       len_a   [NCH];
  logic [TAG_W-1:0]  tag_a   [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign saddr_a[g] = channel_saddr[32*g +: 32];
    assign daddr_a[g] = channel_daddr[32*g +: 32];
    assign len_a[g]   = channel_length[16*g +: 16];
    assign tag_a[g]   = channel_tag[TAG_W*g +: TAG_W];
  end

  logic [NCH-1:0] avail;
  logic           grant_vld;
  logic [CW-1:0]  grant_idx;
  assign avail = channel_req & ~channel_busy;

`ifdef UPSTREAM_RR_ARB_EN
  logic [CW-1:0] rr_ptr;
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(rr_ptr) + k) % NCH;
      if (!grant_vld && avail[idx]) begin
        grant_vld = 1'b1;
        grant_idx = CW'(idx);
      end
    end
  end
`else
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NCH-1; k >= 0; k--) begin
      if (avail[k]) begin
        grant_vld = 1'b1;
        grant_idx = CW'(k);
      end
    end
  end
`endif

  // Fragment never crosses a MAX_FRAG-aligned destination boundary
  logic [16:0] room;
  logic [15:0] frag;
  assign room = 17'(MAX_FRAG) - 17'(dst_r[FW-1:0]);
  assign frag = (17'(rem_r) < room) ? rem_r : 16'(room);

  logic [15:0] ndw, nqw;
  logic [2:0]  end_lo;
  logic [3:0]  fbe_raw, lbe_raw, first_be, last_be;
  logic [1:0]  fv_raw, lv_raw, first_valid, last_valid;
  logic [63:0] desc0, desc1;
  logic [7:0]  data_ctrl;

  always_comb begin
    ndw     = 16'((17'(dst_addr[1:0]) + 17'(byte_length) + 17'd3) >> 2);
    nqw     = 16'((17'(dst_addr[2:0]) + 17'(byte_length) + 17'd7) >> 3);
    end_lo  = dst_addr[2:0] + byte_length[2:0];
    fbe_raw = (4'b1111 >> dst_addr[1:0]) << dst_addr[1:0];
    case (end_lo[1:0])
      2'd1:    lbe_raw = 4'b0001;
      2'd2:    lbe_raw = 4'b0011;
      2'd3:    lbe_raw = 4'b0111;
      default: lbe_raw = 4'b1111;
    endcase
    fv_raw = dst_addr[2] ? 2'b10 : 2'b11;
    lv_raw = (end_lo >= 3'd1 && end_lo <= 3'd4) ? 2'b01 : 2'b11;
    first_be    = (ndw == 16'd1) ? (fbe_raw & lbe_raw) : fbe_raw;
    last_be     = (ndw == 16'd1) ? (fbe_raw & lbe_raw) : lbe_raw;
    first_valid = (nqw == 16'd1) ? (fv_raw & lv_raw) : fv_raw;
    last_valid  = (nqw == 16'd1) ? (fv_raw & lv_raw) : lv_raw;
    desc0 = {32'({tag_r, 4'b0000}), 1'b1, 1'b1, src_addr[3:1], 1'b1, 2'b00,
             first_be, last_be, ndw};
    desc1 = {32'b0, dst_addr[31:2], 2'b00};
    data_ctrl = {4'b0000, (cnt == 16'd1), 1'b1,
                 first ? first_valid : ((cnt == 16'd1) ? last_valid : 2'b11)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ch           <= '0;
      src_r        <= '0;
      dst_r        <= '0;
      rem_r        <= '0;
      cnt          <= '0;
      tag_r        <= '0;
      first        <= 1'b0;
      channel_busy <= '0;
      channel_done <= '0;
      src_addr     <= '0;
      dst_addr     <= '0;
      byte_length  <= '0;
      busif_start  <= 1'b0;
      tohost_data  <= '0;
      tohost_ctrl  <= '0;
      tohost_valid <= 1'b0;
`ifdef UPSTREAM_RR_ARB_EN
      rr_ptr       <= '0;
`endif
    end else begin
      tohost_valid <= 1'b0;
      channel_done <= '0;
      case (state)
        IDLE: if (grant_vld) begin
          ch                      <= grant_idx;
          src_r                   <= saddr_a[grant_idx];
          dst_r                   <= daddr_a[grant_idx];
          rem_r                   <= len_a[grant_idx];
          tag_r                   <= tag_a[grant_idx];
          channel_busy[grant_idx] <= 1'b1;
`ifdef UPSTREAM_RR_ARB_EN
          rr_ptr <= (grant_idx == CW'(NCH-1)) ? '0 : grant_idx + 1'b1;
`endif
          state <= (len_a[grant_idx] == 16'd0) ? DONE : FRAG;
        end
        FRAG: begin
          src_addr    <= src_r;
          dst_addr    <= dst_r;
          byte_length <= frag;
          state       <= INIT;
        end
        INIT: if (!tohost_almost_full) begin
          busif_start  <= 1'b1;
          tohost_valid <= 1'b1;
          tohost_data  <= desc0;
          tohost_ctrl  <= 8'h17;
          state        <= DESC;
        end
        DESC: begin
          tohost_valid <= 1'b1;
          tohost_data  <= desc1;
          cnt          <= nqw;
          first        <= 1'b1;
          state        <= DATA;
        end
        DATA: if (aligner_data_en) begin
          tohost_valid <= 1'b1;
          tohost_data  <= aligner_data;
          tohost_ctrl  <= data_ctrl;
          cnt          <= cnt - 16'd1;
          first        <= 1'b0;
          if (cnt == 16'd1) begin
            busif_start <= 1'b0;
            src_r       <= src_r + 32'(byte_length);
            dst_r       <= dst_r + 32'(byte_length);
            rem_r       <= rem_r - byte_length;
            state       <= (rem_r != byte_length) ? FRAG : DONE;
          end
        end
        DONE: begin
          channel_done[ch] <= 1'b1;
          channel_busy[ch] <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_upstream_req_n_data_mc.sv
// Directed bench for upstream_req_n_data_mc with hand-computed descriptor/ctrl values.
module tb_upstream_req_n_data_mc;
  localparam int NCH = 4;
  localparam int TAG_W = 4;
  localparam logic [63:0] ALN = 64'h0123_4567_89AB_CDEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]       channel_req = '0;
  logic [NCH*32-1:0]    channel_saddr = '0;
  logic [NCH*32-1:0]    channel_daddr = '0;
  logic [NCH*16-1:0]    channel_length = '0;
  logic [NCH*TAG_W-1:0] channel_tag = '0;
  logic [NCH-1:0]       channel_busy, channel_done;
  logic [31:0]          src_addr, dst_addr;
  logic [15:0]          byte_length;
  logic                 busif_start;
  logic [63:0]          aligner_data;
  logic                 aligner_data_en;
  logic                 tohost_almost_full = 1'b0;
  logic [63:0]          tohost_data;
  logic [7:0]           tohost_ctrl;
  logic                 tohost_valid;
  logic                 en_gate = 1'b1;

  assign aligner_data    = ALN;
  assign aligner_data_en = busif_start & en_gate;

  upstream_req_n_data_mc #(.NCH(NCH), .TAG_W(TAG_W), .MAX_FRAG(512)) dut (
    .clk(clk), .rst_n(rst_n),
    .channel_req(channel_req), .channel_saddr(channel_saddr),
    .channel_daddr(channel_daddr), .channel_length(channel_length),
    .channel_tag(channel_tag), .channel_busy(channel_busy),
    .channel_done(channel_done), .src_addr(src_addr), .dst_addr(dst_addr),
    .byte_length(byte_length), .busif_start(busif_start),
    .aligner_data(aligner_data), .aligner_data_en(aligner_data_en),
    .tohost_almost_full(tohost_almost_full), .tohost_data(tohost_data),
    .tohost_ctrl(tohost_ctrl), .tohost_valid(tohost_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct packed {logic [7:0] ctrl; logic [63:0] data;} wr_t;
  wr_t q[$];
  int  grants[$];
  int  done_cnt[NCH];
  logic [NCH-1:0] busy_d = '0;

  always @(negedge clk) begin
    if (tohost_valid) q.push_back({tohost_ctrl, tohost_data});
    for (int i = 0; i < NCH; i++) begin
      if (channel_done[i]) done_cnt[i]++;
      if (channel_busy[i] && !busy_d[i]) grants.push_back(i);
    end
    busy_d <= channel_busy;
  end

  task automatic clear_logs();
    q.delete();
    grants.delete();
    for (int i = 0; i < NCH; i++) done_cnt[i] = 0;
  endtask

  task automatic setup_ch(input int c, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] len, input logic [TAG_W-1:0] tag);
    channel_saddr[32*c +: 32]      = s;
    channel_daddr[32*c +: 32]      = d;
    channel_length[16*c +: 16]     = len;
    channel_tag[TAG_W*c +: TAG_W]  = tag;
  endtask

  task automatic grant_wait(input int c, input string nm);
    logic seen;
    seen = 1'b0;
    channel_req[c] = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = channel_busy[c];
    end
    channel_req[c] = 1'b0;
    chk({nm, "_grant"}, 64'(seen), 64'd1);
  endtask

  task automatic done_wait(input int c, input string nm);
    for (int i = 0; i < 2000 && done_cnt[c] == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({nm, "_done_cnt"}, 64'(done_cnt[c]), 64'd1);
  endtask

  initial begin
    #1;
    chk("rst_valid", 64'(tohost_valid), 64'd0);
    chk("rst_busy",  64'(channel_busy), 64'd0);
    chk("rst_start", 64'(busif_start), 64'd0);
    chk("rst_data",  tohost_data, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 64 bytes aligned: 8 full qwords
    clear_logs();
    setup_ch(0, 32'h0000_2000, 32'h0000_1000, 16'd64, 4'h5);
    grant_wait(0, "t1");
    done_wait(0, "t1");
    chk("t1_nwr", 64'(q.size()), 64'd10);
    if (q.size() == 10) begin
      chk("t1_desc0", q[0].data, 64'h0000_0050_C4FF_0010);
      chk("t1_ctrl0", 64'(q[0].ctrl), 64'h17);
      chk("t1_desc1", q[1].data, 64'h0000_0000_0000_1000);
      chk("t1_ctrl1", 64'(q[1].ctrl), 64'h17);
      chk("t1_pay", q[2].data, ALN);
      for (int i = 0; i < 8; i++)
        chk($sformatf("t1_dctrl%0d", i), 64'(q[2+i].ctrl), (i == 7) ? 64'h0F : 64'h07);
    end

    // unaligned 5 bytes: ndw=2, single qword
    clear_logs();
    setup_ch(1, 32'h0000_3006, 32'h0000_1003, 16'd5, 4'hA);
    grant_wait(1, "t2");
    done_wait(1, "t2");
    chk("t2_nwr", 64'(q.size()), 64'd3);
    if (q.size() == 3) begin
      chk("t2_desc0", q[0].data, 64'h0000_00A0_DC8F_0002);
      chk("t2_desc1", q[1].data, 64'h0000_0000_0000_1000);
      chk("t2_dctrl", 64'(q[2].ctrl), 64'h0F);
    end

    // boundary crossing: 0x10 + 0x30
    clear_logs();
    setup_ch(0, 32'h0000_4000, 32'h0000_01F0, 16'h40, 4'h0);
    grant_wait(0, "t3");
    done_wait(0, "t3");
    chk("t3_nwr", 64'(q.size()), 64'd12);
    if (q.size() == 12) begin
      chk("t3_f1_desc0", q[0].data, 64'h0000_0000_C4FF_0004);
      chk("t3_f1_desc1", q[1].data, 64'h0000_0000_0000_01F0);
      chk("t3_f1_last",  64'(q[3].ctrl), 64'h0F);
      chk("t3_f2_desc0", q[4].data, 64'h0000_0000_C4FF_000C);
      chk("t3_f2_desc1", q[5].data, 64'h0000_0000_0000_0200);
      chk("t3_f2_last",  64'(q[11].ctrl), 64'h0F);
    end
    chk("t3_src", 64'(src_addr), 64'h4010);
    chk("t3_len", 64'(byte_length), 64'h30);

    // almost_full stall in INIT
    clear_logs();
    tohost_almost_full = 1'b1;
    setup_ch(2, 32'h0000_0100, 32'h0000_1000, 16'd8, 4'h3);
    grant_wait(2, "t4");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t4_valid%0d", i), 64'(tohost_valid), 64'd0);
      chk($sformatf("t4_start%0d", i), 64'(busif_start), 64'd0);
    end
    tohost_almost_full = 1'b0;
    done_wait(2, "t4");
    chk("t4_nwr", 64'(q.size()), 64'd3);
    if (q.size() == 3) chk("t4_dctrl", 64'(q[2].ctrl), 64'h0F);

    // zero length: done two cycles after the request is seen
    clear_logs();
    setup_ch(3, 32'h0, 32'h0000_1000, 16'd0, 4'h1);
    channel_req[3] = 1'b1;
    @(posedge clk); #1;
    channel_req[3] = 1'b0;
    chk("t5_busy", 64'(channel_busy[3]), 64'd1);
    chk("t5_done_early", 64'(channel_done[3]), 64'd0);
    @(posedge clk); #1;
    chk("t5_done", 64'(channel_done[3]), 64'd1);
    repeat (4) @(negedge clk);
    chk("t5_done_cnt", 64'(done_cnt[3]), 64'd1);
    chk("t5_nwr", 64'(q.size()), 64'd0);

    // reset in the middle of DATA
    clear_logs();
    en_gate = 1'b0;
    setup_ch(1, 32'h0000_5000, 32'h0000_1000, 16'd64, 4'h7);
    grant_wait(1, "t6");
    repeat (6) @(negedge clk);
    chk("t6_started", 64'(busif_start), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 64'(tohost_valid), 64'd0);
    chk("t6_start", 64'(busif_start), 64'd0);
    chk("t6_busy",  64'(channel_busy), 64'd0);
    chk("t6_data",  tohost_data, 64'd0);
    chk("t6_ctrl",  64'(tohost_ctrl), 64'd0);
    chk("t6_len",   64'(byte_length), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en_gate = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_no_done", 64'(done_cnt[1]), 64'd0);
    clear_logs();
    setup_ch(1, 32'h0000_3006, 32'h0000_1003, 16'd5, 4'hA);
    grant_wait(1, "t6r");
    done_wait(1, "t6r");
    chk("t6r_nwr", 64'(q.size()), 64'd3);

    // arbitration under continuous requests on ch0 and ch2
    clear_logs();
    setup_ch(0, 32'h0, 32'h0000_1000, 16'd8, 4'h0);
    setup_ch(2, 32'h0, 32'h0000_2000, 16'd8, 4'h2);
    channel_req = 4'b0101;
    for (int i = 0; i < 500 && grants.size() < 4; i++) @(negedge clk);
    channel_req = '0;
    for (int i = 0; i < 200 && channel_busy != '0; i++) @(negedge clk);
    chk("t7_ngrant", 64'(grants.size() >= 4), 64'd1);
    if (grants.size() >= 4) begin
`ifdef UPSTREAM_RR_ARB_EN
      chk("t7_g0", 64'(grants[0]), 64'd0);
      chk("t7_g1", 64'(grants[1]), 64'd2);
      chk("t7_g2", 64'(grants[2]), 64'd0);
      chk("t7_g3", 64'(grants[3]), 64'd2);
`else
      for (int i = 0; i < 4; i++) chk($sformatf("t7_g%0d", i), 64'(grants[i]), 64'd0);
`endif
    end
    chk("t7_idle", 64'(channel_busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
